// File: rtl/fsab_rd_arbiter_pkg.sv
// FSAB field widths and read-arbiter constants shared by the arbiter and its picker.
package fsab_rd_arbiter_pkg;

  localparam int unsigned FSAB_ADDR_HI         = 30;
  localparam int unsigned FSAB_DID_HI          = 3;
  localparam int unsigned FSAB_LEN_HI          = 6;
  localparam int unsigned FSAB_DATA_HI         = 63;
  localparam int unsigned FSAB_MASK_HI         = 7;
  localparam int unsigned FSAB_CREDITS_HI      = 2;
  localparam int unsigned FSAB_INITIAL_CREDITS = 4;

  localparam logic FSAB_READ  = 1'b1;
  localparam logic FSAB_WRITE = 1'b0;

  // Largest requester count the read arbiter supports, plus packed-slice widths.
  localparam int unsigned RD_ARB_MAX_NREQ = 4;
  localparam int unsigned FSAB_ADDR_W     = FSAB_ADDR_HI + 1;
  localparam int unsigned FSAB_DID_W      = FSAB_DID_HI + 1;

  function automatic int unsigned rd_arb_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsab_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; search starts one past the last winner.
module fsab_rd_arbiter_rr_pick
  import fsab_rd_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = rd_arb_idx_w(N)
) (
  input  logic [N-1:0]     i_elig,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int unsigned w_cand;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = 0;
    // Walk farthest-to-nearest so the nearest eligible requester overwrites the rest.
    for (int unsigned k = N; k >= 1; k--) begin
      w_cand = (32'(i_last) + k) % N;
      if (i_elig[w_cand]) begin
        o_onehot = N'(1) << w_cand;
        o_idx    = IDX_W'(w_cand);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsab_rd_arbiter.sv
// Round-robin FSAB read-request arbiter with credit budget and per-engine outstanding cap.
module fsab_rd_arbiter
  import fsab_rd_arbiter_pkg::*;
#(
  parameter int unsigned          NREQ            = 2,
  parameter int unsigned          MAX_OUTSTANDING = 1,
  parameter logic [FSAB_LEN_HI:0] RD_LEN          = 'h8
) (
  input  logic                        target_clk,
  input  logic                        target_rst_b,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*FSAB_ADDR_W-1:0] req_addr,
  input  logic [NREQ*FSAB_DID_W-1:0]  req_did,
  input  logic [NREQ*FSAB_DID_W-1:0]  req_subdid,
  output logic [NREQ-1:0]             req_grant,
  input  logic [NREQ-1:0]             req_done,
  output logic                        arb__fsabo_valid,
  output logic                        arb__fsabo_mode,
  output logic [FSAB_DID_HI:0]        arb__fsabo_did,
  output logic [FSAB_DID_HI:0]        arb__fsabo_subdid,
  output logic [FSAB_ADDR_HI:0]       arb__fsabo_addr,
  output logic [FSAB_LEN_HI:0]        arb__fsabo_len,
  output logic [FSAB_DATA_HI:0]       arb__fsabo_data,
  output logic [FSAB_MASK_HI:0]       arb__fsabo_mask,
  input  logic                        arb__fsabo_credit
);

  localparam int unsigned IDX_W  = rd_arb_idx_w(NREQ);
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CRED_W = FSAB_CREDITS_HI + 1;

  if (NREQ < 2 || NREQ > RD_ARB_MAX_NREQ || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 3)
  begin : g_bad_params
    $error("fsab_rd_arbiter: NREQ or MAX_OUTSTANDING out of range");
  end

  logic [CRED_W-1:0]   r_credits, w_credits_d;
  logic [IDX_W-1:0]    r_last_grant, w_idx;
  logic [NREQ-1:0]     w_elig, w_onehot;
  logic                w_any;
  logic [CNT_W-1:0]    r_out_cnt [NREQ];

  logic                r_valid, r_mode;
  logic [FSAB_DID_HI:0]  r_did, r_subdid;
  logic [FSAB_ADDR_HI:0] r_addr;
  logic [FSAB_LEN_HI:0]  r_len;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      w_elig[i] = req_valid[i] && (r_out_cnt[i] < CNT_W'(MAX_OUTSTANDING)) && (r_credits != '0);
    end
  end

  fsab_rd_arbiter_rr_pick #(
    .N (NREQ)
  ) u_rr_pick (
    .i_elig   (w_elig),
    .i_last   (r_last_grant),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign req_grant = w_onehot;

  always_comb begin
    w_credits_d = r_credits;
    if (arb__fsabo_credit && !w_any) begin
      w_credits_d = r_credits + 1'b1;
    end else if (!arb__fsabo_credit && w_any) begin
      w_credits_d = r_credits - 1'b1;
    end
  end

  always_ff @(posedge target_clk or negedge target_rst_b) begin
    if (!target_rst_b) begin
      r_credits    <= CRED_W'(FSAB_INITIAL_CREDITS);
      r_last_grant <= IDX_W'(NREQ - 1);
    end else begin
      r_credits <= w_credits_d;
      if (w_any) begin
        r_last_grant <= w_idx;
      end
    end
  end

  // A done pulse with nothing outstanding is ignored so the counter cannot wrap.
  always_ff @(posedge target_clk or negedge target_rst_b) begin
    if (!target_rst_b) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        r_out_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (w_onehot[i] && !req_done[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
        end else if (!w_onehot[i] && req_done[i] && (r_out_cnt[i] != '0)) begin
          r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge target_clk or negedge target_rst_b) begin
    if (!target_rst_b) begin
      r_valid  <= 1'b0;
      r_mode   <= 1'b0;
      r_did    <= '0;
      r_subdid <= '0;
      r_addr   <= '0;
      r_len    <= '0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_mode   <= FSAB_READ;
        r_did    <= req_did[32'(w_idx) * FSAB_DID_W +: FSAB_DID_W];
        r_subdid <= req_subdid[32'(w_idx) * FSAB_DID_W +: FSAB_DID_W];
        r_addr   <= req_addr[32'(w_idx) * FSAB_ADDR_W +: FSAB_ADDR_W];
        r_len    <= RD_LEN;
      end else begin
        r_mode   <= 1'b0;
        r_did    <= '0;
        r_subdid <= '0;
        r_addr   <= '0;
        r_len    <= '0;
      end
    end
  end

  assign arb__fsabo_valid  = r_valid;
  assign arb__fsabo_mode   = r_mode;
  assign arb__fsabo_did    = r_did;
  assign arb__fsabo_subdid = r_subdid;
  assign arb__fsabo_addr   = r_addr;
  assign arb__fsabo_len    = r_len;
  assign arb__fsabo_data   = '0;
  assign arb__fsabo_mask   = '0;

endmodule

// File: tb/tb_fsab_rd_arbiter.sv
// Directed bench: dut_a is 4 requesters / cap 1, dut_b is 2 requesters / cap 3.
module tb_fsab_rd_arbiter;
  import fsab_rd_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0]               a_valid, a_grant, a_done;
  logic [4*FSAB_ADDR_W-1:0] a_addr;
  logic [4*FSAB_DID_W-1:0]  a_did, a_subdid;
  logic                     a_fv, a_mode, a_credit;
  logic [FSAB_DID_HI:0]     a_fdid, a_fsub;
  logic [FSAB_ADDR_HI:0]    a_faddr;
  logic [FSAB_LEN_HI:0]     a_flen;
  logic [FSAB_DATA_HI:0]    a_fdata;
  logic [FSAB_MASK_HI:0]    a_fmask;

  logic [1:0]               b_valid, b_grant, b_done;
  logic [2*FSAB_ADDR_W-1:0] b_addr;
  logic [2*FSAB_DID_W-1:0]  b_did, b_subdid;
  logic                     b_fv, b_mode, b_credit;
  logic [FSAB_DID_HI:0]     b_fdid, b_fsub;
  logic [FSAB_ADDR_HI:0]    b_faddr;
  logic [FSAB_LEN_HI:0]     b_flen;
  logic [FSAB_DATA_HI:0]    b_fdata;
  logic [FSAB_MASK_HI:0]    b_fmask;

  fsab_rd_arbiter #(.NREQ(4), .MAX_OUTSTANDING(1), .RD_LEN('h8)) dut_a (
    .target_clk (clk), .target_rst_b (rst_b),
    .req_valid (a_valid), .req_addr (a_addr), .req_did (a_did), .req_subdid (a_subdid),
    .req_grant (a_grant), .req_done (a_done),
    .arb__fsabo_valid (a_fv), .arb__fsabo_mode (a_mode), .arb__fsabo_did (a_fdid),
    .arb__fsabo_subdid (a_fsub), .arb__fsabo_addr (a_faddr), .arb__fsabo_len (a_flen),
    .arb__fsabo_data (a_fdata), .arb__fsabo_mask (a_fmask), .arb__fsabo_credit (a_credit)
  );

  fsab_rd_arbiter #(.NREQ(2), .MAX_OUTSTANDING(3), .RD_LEN('h8)) dut_b (
    .target_clk (clk), .target_rst_b (rst_b),
    .req_valid (b_valid), .req_addr (b_addr), .req_did (b_did), .req_subdid (b_subdid),
    .req_grant (b_grant), .req_done (b_done),
    .arb__fsabo_valid (b_fv), .arb__fsabo_mode (b_mode), .arb__fsabo_did (b_fdid),
    .arb__fsabo_subdid (b_fsub), .arb__fsabo_addr (b_faddr), .arb__fsabo_len (b_flen),
    .arb__fsabo_data (b_fdata), .arb__fsabo_mask (b_fmask), .arb__fsabo_credit (b_credit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_b = 1'b0;
    a_valid = '0; a_done = '0; a_credit = 1'b0; a_addr = '0; a_did = '0; a_subdid = '0;
    b_valid = '0; b_done = '0; b_credit = 1'b0; b_addr = '0; b_did = '0; b_subdid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  // Check a_grant on the next falling edge, then advance past the next rising edge.
  task automatic step_a(input logic [3:0] exp, input string name);
    @(negedge clk);
    checks++;
    if (a_grant !== exp) begin
      failures++;
      $display("FAIL %s: grant got %b want %b", name, a_grant, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({a_fv, a_mode, a_fdid, a_fsub, a_faddr, a_flen, a_fdata, a_fmask} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_a: got valid=%b addr=%h len=%h want all zero",
               a_fv, a_faddr, a_flen);
    end
    checks++;
    if ({b_fv, b_faddr, b_flen} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_b: got valid=%b addr=%h want zero", b_fv, b_faddr);
    end
    checks++;
    if (a_grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_grant: got %b want 0000", a_grant);
    end
  endtask

  task automatic test_single();
    apply_reset();
    a_valid = 4'b0001;
    a_addr[0 +: FSAB_ADDR_W] = 31'h1000;
    a_did[0 +: FSAB_DID_W] = 4'h3;
    a_subdid[0 +: FSAB_DID_W] = 4'h5;
    step_a(4'b0001, "single_first_grant");
    a_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if ({a_fv, a_faddr, a_flen, a_mode, a_fdid, a_fsub}
        !== {1'b1, 31'h1000, 7'h8, FSAB_READ, 4'h3, 4'h5}) begin
      failures++;
      $display("FAIL single_request_fields: got v=%b addr=%h len=%h mode=%b did=%h sub=%h",
               a_fv, a_faddr, a_flen, a_mode, a_fdid, a_fsub);
    end
    tick();
    a_valid = 4'b0001;
    a_addr[0 +: FSAB_ADDR_W] = 31'h2000;
    @(negedge clk);
    checks++;
    if ({a_fv, a_faddr, a_grant} !== '0) begin
      failures++;
      $display("FAIL single_blocked_idle: got v=%b addr=%h grant=%b want 0", a_fv, a_faddr,
               a_grant);
    end
    tick();
    step_a(4'b0000, "single_still_blocked");
    a_done = 4'b0001;
    step_a(4'b0000, "single_done_same_cycle");
    a_done = 4'b0000;
    step_a(4'b0001, "single_regrant_after_done");
    a_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if ({a_fv, a_faddr} !== {1'b1, 31'h2000}) begin
      failures++;
      $display("FAIL single_second_addr: got v=%b addr=%h want 1 2000", a_fv, a_faddr);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp, prev;
    apply_reset();
    b_addr = {31'h200, 31'h100};
    b_valid = 2'b11;
    b_credit = 1'b1;
    exp = 2'b01;
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (b_grant !== exp) begin
        failures++;
        $display("FAIL alternate_grant[%0d]: got %b want %b", i, b_grant, exp);
      end
      if (i > 0) begin
        checks++;
        if ({b_fv, b_faddr} !== {1'b1, (prev == 2'b01) ? 31'h100 : 31'h200}) begin
          failures++;
          $display("FAIL alternate_addr[%0d]: got v=%b addr=%h", i, b_fv, b_faddr);
        end
      end
      tick();
      b_done = exp;
      prev = exp;
      exp = {exp[0], exp[1]};
    end
    b_valid = 2'b00;
    b_credit = 1'b0;
    tick();
    b_done = 2'b00;
  endtask

  task automatic test_credits();
    apply_reset();
    a_valid = 4'b1100;
    step_a(4'b0100, "credits_pre_2");
    step_a(4'b1000, "credits_pre_3");
    a_valid = 4'b0000;
    a_done = 4'b1100;
    step_a(4'b0000, "credits_idle");
    a_done = 4'b0000;
    a_valid = 4'b1111;
    step_a(4'b0001, "credits_grant_0");
    step_a(4'b0010, "credits_grant_1");
    step_a(4'b0000, "credits_exhausted_a");
    step_a(4'b0000, "credits_exhausted_b");
    a_credit = 1'b1;
    step_a(4'b0000, "credits_return_cycle");
    a_credit = 1'b0;
    step_a(4'b0100, "credits_after_return");
    step_a(4'b0000, "credits_exhausted_again");
  endtask

  task automatic test_credit_and_grant();
    apply_reset();
    a_valid = 4'b0111;
    step_a(4'b0001, "cg_pre_0");
    step_a(4'b0010, "cg_pre_1");
    step_a(4'b0100, "cg_pre_2");
    a_valid = 4'b1000;
    a_credit = 1'b1;
    a_done = 4'b0001;
    step_a(4'b1000, "cg_simultaneous");
    a_valid = 4'b0001;
    a_credit = 1'b0;
    a_done = 4'b0010;
    step_a(4'b0001, "cg_credit_kept");
    a_valid = 4'b0010;
    a_done = 4'b0000;
    step_a(4'b0000, "cg_now_empty");
  endtask

  task automatic test_spurious_done();
    apply_reset();
    a_done = 4'b0010;
    step_a(4'b0000, "spurious_idle");
    a_done = 4'b0000;
    a_valid = 4'b0010;
    a_addr[FSAB_ADDR_W +: FSAB_ADDR_W] = 31'h3000;
    step_a(4'b0010, "spurious_then_grant");
    @(negedge clk);
    checks++;
    if ({a_grant, a_fv, a_faddr} !== {4'b0000, 1'b1, 31'h3000}) begin
      failures++;
      $display("FAIL spurious_cap_held: got grant=%b v=%b addr=%h want 0000 1 3000",
               a_grant, a_fv, a_faddr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a_valid = 4'b1111;
    a_addr = {31'h4444, 31'h3333, 31'h2222, 31'h1111};
    step_a(4'b0001, "mid_first");
    checks++;
    if (a_fv !== 1'b1) begin
      failures++;
      $display("FAIL mid_valid_before_reset: got %b want 1", a_fv);
    end
    #2;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({a_fv, a_faddr} !== '0) begin
      failures++;
      $display("FAIL mid_async_drop: got v=%b addr=%h want 0", a_fv, a_faddr);
    end
    tick();
    rst_b = 1'b1;
    step_a(4'b0001, "mid_after_0");
    step_a(4'b0010, "mid_after_1");
    step_a(4'b0100, "mid_after_2");
    step_a(4'b1000, "mid_after_3");
    step_a(4'b0000, "mid_after_exhausted");
    a_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_credits();
    test_credit_and_grant();
    test_spurious_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
